// File: rtl/printer_pkg.sv
// printer_pkg: opcode encodings, operand width and operand struct for the
// printer ALU block.
package printer_pkg;

  localparam int OPW = 4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_PASSA = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;
  localparam logic [3:0] ALU_NOTA  = 4'b1101;
  localparam logic [3:0] ALU_INCA  = 4'b1110;
  localparam logic [3:0] ALU_DECA  = 4'b1111;

  // packed operand bus: A in the upper nibble, B in the lower
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } ops_t;

endpackage

// File: rtl/printer_alu.sv
// printer_alu: purely combinational 4-bit ALU, 16 opcodes, all defined.
module printer_alu
  import printer_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic [3:0]     aluc,
  output logic [OPW-1:0] y
);

  logic [1:0] sh;
  assign sh = b[1:0];

  // opcode decode; every result is truncated to the operand width
  always_comb begin
    y = '0;
    case (aluc)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_NOR:   y = ~(a | b);
      ALU_SLT:   y = {3'b000, ($signed(a) < $signed(b))};
      ALU_SLTU:  y = {3'b000, (a < b)};
      ALU_SLL:   y = a << sh;
      ALU_SRL:   y = a >> sh;
      ALU_SRA:   y = $unsigned($signed(a) >>> sh);
      ALU_PASSA: y = a;
      ALU_PASSB: y = b;
      ALU_NOTA:  y = ~a;
      ALU_INCA:  y = a + 4'd1;
      ALU_DECA:  y = a - 4'd1;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/printer.sv
// printer: registered 4-bit ALU. res captures the ALU result every rising
// edge; async active-high reset clears it. Optional trace under the
// PRINTER_DISPLAY_EN macro (simulation only).
module printer
  import printer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     ops,
  input  logic [3:0]     aluc,
  output logic [OPW-1:0] res
);

  ops_t           op;
  logic [OPW-1:0] y;

  assign op = ops_t'(ops);

  printer_alu u_alu (
    .a    (op.a),
    .b    (op.b),
    .aluc (aluc),
    .y    (y)
  );

  // result register, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res <= '0;
    else     res <= y;
  end

`ifdef PRINTER_DISPLAY_EN
  // trace line per accepted operation, showing the value res is about to take
  always @(posedge clk) begin
    if (!rst)
      $display("%0t op=%b A=%b B=%b res=%b", $time, aluc, op.a, op.b, y);
  end
`else
`endif

endmodule

// File: tb/tb_printer.sv
// tb_printer: directed and randomized checks of printer against an
// arithmetic reference model.
module tb_printer;

  logic       clk;
  logic       rst;
  logic [7:0] ops;
  logic [3:0] aluc;
  logic [3:0] res;

  int total = 0;
  int bad   = 0;

  printer dut (
    .clk  (clk),
    .rst  (rst),
    .ops  (ops),
    .aluc (aluc),
    .res  (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: plain integer arithmetic on A and B, reduced modulo 16
  function automatic logic [3:0] model(input int a, input int b, input int op);
    int sa, sb, s, p, r;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    s  = b % 4;
    p  = 1 << s;
    case (op)
      0:  r = a + b;
      1:  r = a - b + 16;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 15 - (a | b);
      6:  r = (sa < sb) ? 1 : 0;
      7:  r = (a < b) ? 1 : 0;
      8:  r = a * p;
      9:  r = a / p;
      10: r = ((sa < 0) ? (sa - (p - 1)) / p : sa / p) + 16;
      11: r = a;
      12: r = b;
      13: r = 15 - a;
      14: r = a + 1;
      default: r = a + 15;
    endcase
    return 4'(r % 16);
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    total++;
    assert (res === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, res, exp);
    end
  endtask

  // drive at negedge, sample 1 time unit after the following posedge
  task automatic step(input logic [7:0] o, input logic [3:0] c);
    @(negedge clk);
    ops  = o;
    aluc = c;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] prev;

  initial begin
    rst  = 1'b0;
    ops  = 8'hAB;
    aluc = 4'b0000;
    #2 rst = 1'b1;
    #1 check("reset_async", 4'b0000);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", 4'b0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release", 4'b0101);

    // AND, with a look before the edge
    @(negedge clk);
    ops = {4'b1010, 4'b1011}; aluc = 4'b0010;
    #1 check("and_pre_edge", 4'b0101);
    @(posedge clk); #1;
    check("and", 4'b1010);

    step({4'b1111, 4'b0001}, 4'b0000); check("add_wrap", 4'b0000);
    step({4'b0000, 4'b0001}, 4'b0001); check("sub_wrap", 4'b1111);
    step({4'b1111, 4'b0000}, 4'b1110); check("inca_wrap", 4'b0000);
    step({4'b0000, 4'b0101}, 4'b1111); check("deca_wrap", 4'b1111);
    step({4'b1000, 4'b0001}, 4'b0110); check("slt", 4'b0001);
    step({4'b1000, 4'b0001}, 4'b0111); check("sltu", 4'b0000);
    step({4'b1010, 4'b0110}, 4'b1000); check("sll", 4'b1000);
    step({4'b1010, 4'b0110}, 4'b1001); check("srl", 4'b0010);
    step({4'b1010, 4'b0110}, 4'b1010); check("sra", 4'b1110);

    // input changes between edges must not reach res
    step({4'b0011, 4'b0101}, 4'b0011); check("or", 4'b0111);
    @(negedge clk);
    aluc = 4'b0100;
    #2 aluc = 4'b0010;
    #1 check("mid_change_hold", 4'b0111);
    @(posedge clk); #1;
    check("mid_change_edge", 4'b0001);

    // reset between edges clears at once
    @(negedge clk);
    aluc = 4'b1011;
    #1 rst = 1'b1;
    #1 check("mid_reset", 4'b0000);
    @(posedge clk); #1;
    check("mid_reset_edge", 4'b0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("after_mid_reset", 4'b0011);

    // randomized operations against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] o;
      logic [3:0] c;
      o = 8'($urandom);
      c = 4'($urandom_range(0, 15));
      step(o, c);
      check("random", model(int'(o[7:4]), int'(o[3:0]), int'(c)));
    end

    // exhaustive sweep of every opcode over every operand pair
    for (int c = 0; c < 16; c++)
      for (int o = 0; o < 256; o++) begin
        step(8'(o), 4'(c));
        check("sweep", model(o / 16, o % 16, c));
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/printer.md
# printer

Registered 4-bit ALU whose result is captured into an output register on every rising clock edge. A single 8-bit operand bus carries both operands, and a 4-bit opcode selects one of 16 operations. It sits as a small datapath leaf: combinational ALU core plus a result register, with optional simulation trace output.

## Interface
- Parameters: none. Widths are fixed at 4-bit operands, 4-bit opcode and 4-bit result.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ops  input  8  packed operands: ops[7:4] = A (op1), ops[3:0] = B (op2).
- aluc  input  4  operation select.
- res  output  4  registered result.

## Operation
- Opcodes (A = ops[7:4], B = ops[3:0]; all results truncated to 4 bits):
  - 0000 ADD: A+B, carry dropped.
  - 0001 SUB: A−B, borrow dropped.
  - 0010 AND: A&B.
  - 0011 OR: A|B.
  - 0100 XOR: A^B.
  - 0101 NOR: ~(A|B).
  - 0110 SLT: {3'b0, signed A < signed B}.
  - 0111 SLTU: {3'b0, A < B unsigned}.
  - 1000 SLL: A << B[1:0].
  - 1001 SRL: A >> B[1:0], logical.
  - 1010 SRA: A >>> B[1:0], arithmetic, sign bit A[3] replicated.
  - 1011 PASSA: A.
  - 1100 PASSB: B.
  - 1101 NOTA: ~A.
  - 1110 INCA: A+1, wraps 1111→0000.
  - 1111 DECA: A−1, wraps 0000→1111.
- Shift amounts use only B[1:0]. B[3:2] are ignored for shifts.
- Every opcode is defined; the block has no illegal or hold case.

## Timing
- res resets to 4'b0000 immediately when rst is asserted, without waiting for a clock edge.
- res holds 0 while rst is high.
- Latency: one cycle. At each rising clk edge with rst low, res takes the ALU result of the ops and aluc values sampled at that edge.
- Input changes between edges do not affect res.
- When rst deasserts, the first update occurs at the next rising edge.
- If rst asserts mid-operation, res clears at once and the pending result is lost.
- No handshake and no stall. A new operation is accepted every cycle.

## Configuration
- PRINTER_DISPLAY_EN defined: on every rising clk edge with rst low, the block emits one simulation line: "$time op=<aluc bin> A=<bin> B=<bin> res=<next res bin>". This trace is simulation-only and non-synthesizable; guard it with `ifdef`.
- PRINTER_DISPLAY_EN undefined: no trace output. Register behaviour is identical either way.

## Structure
- Package printer_pkg holds:
  - localparams for the 16 aluc encodings (ALU_ADD … ALU_DECA);
  - the operand width constant (4).
- Sub-module printer_alu is purely combinational: inputs (a, b, aluc), output y.
- The top-level printer instantiates printer_alu, holds the res register, and contains the optional display block.

## Test plan
- Reset behaviour: assert rst with ops=8'hAB, aluc=0000 → res=0000 asynchronously and through clock edges. Release rst → res=0101 after the next edge.
- AND op: ops={1010,1011}, aluc=0010, one rising edge → res=1010. Before the edge, res keeps its previous value.
- Arithmetic wrap: ADD with A=1111, B=0001 → 0000. SUB with A=0000, B=0001 → 1111. INCA with A=1111 → 0000.
- Signed vs unsigned compare: A=1000, B=0001. SLT → 0001, SLTU → 0000.
- Shifts with A=1010 and B=0110 (so B[1:0]=10): SLL → 1000, SRL → 0010, SRA → 1110.
- Mid-stream reset and sampling: change aluc between edges → res changes only at the edge. Assert rst between edges → res clears immediately.
